uart_frame_ctrl: RTL
====================

// Module: uart_frame_ctrl
// PURPOSE
//  Command-frame controller between the UART byte receiver (po_data/po_flag) and the
//  6-digit seven-segment display driver. Parses 6-byte frames: AA, CMD, D2, D1, D0, CHK.
//  Checks each frame and updates the display configuration registers.
//  Reports a per-frame OK/ERR result. Drops partial frames on an inter-byte timeout.
// PARAMETERS
//  TIMEOUT_MAX  500_000  max sys_clk cycles between bytes of one frame (10 ms @ 50 MHz)
//  DATA_MAX     999_999  largest value accepted by CMD 0x01 (6 decimal digits)
// PORTS
//  sys_clk    in   1   system clock, 50 MHz
//  sys_rst_n  in   1   asynchronous active-low reset
//  pi_data    in   8   received byte from UART receiver
//  pi_flag    in   1   one-cycle strobe: pi_data valid
//  data       out  20  display value, binary, 0..DATA_MAX
//  point      out  6   decimal-point enable per digit, bit0 = rightmost
//  sign       out  1   1 = show minus sign
//  seg_en     out  1   1 = display on
//  frame_ok   out  1   one-cycle pulse: frame accepted and applied
//  frame_err  out  1   one-cycle pulse: frame rejected
//  err_code   out  2   last error: 00 none, 01 checksum, 10 bad cmd/range, 11 timeout
// BEHAVIOUR
//  Reset values: data=0, point=0, sign=0, seg_en=1, frame_ok=0, frame_err=0,
//   err_code=00, state=IDLE, timeout counter=0, byte registers=0.
//  FSM states: IDLE -> CMD -> D2 -> D1 -> D0 -> CHK -> EXEC -> IDLE.
//   A state advances only on a cycle with pi_flag=1.
//  IDLE: pi_flag with pi_data==8'hAA -> CMD. Any other byte is discarded; no error.
//  CMD/D2/D1/D0: latch pi_data into the matching register and advance.
//   0xAA is ordinary data here; there is no mid-frame resync.
//  CHK: sum = CMD+D2+D1+D0, mod 256 (8-bit wrap).
//   Match -> EXEC.
//   Mismatch -> IDLE, frame_err pulse, err_code=01.
//  EXEC (exactly one cycle), then unconditionally IDLE:
//   CMD 01: v={D2[3:0],D1,D0}. If D2[7:4]==0 and v<=DATA_MAX: data<=v, ok.
//    Otherwise: error 10, data unchanged.
//   CMD 02: point<=D0[5:0], ok. D0[7:6], D2 and D1 are ignored.
//   CMD 03: seg_en<=D0[0], sign<=D0[1], ok.
//   Any other CMD: error 10.
//   ok means: frame_ok pulse and err_code<=00.
//  Latency: outputs and the frame_ok/frame_err pulse are visible 2 clocks after the cycle
//   pi_flag carries CHK (CHK cycle -> EXEC -> update).
//   A checksum failure pulses frame_err 1 clock after the CHK cycle.
//  frame_ok and frame_err are never high together. Each pulse lasts exactly 1 cycle.
//  err_code holds its value until the next frame result.
//  Timeout: a 20-bit counter runs in CMD..CHK and clears on every pi_flag and in IDLE/EXEC.
//   When it reaches TIMEOUT_MAX-1 without pi_flag: go to IDLE, frame_err pulse,
//   err_code=11. Registers are not touched.
//  Simultaneous timeout expiry and pi_flag: the byte wins. The counter clears and the byte
//   is processed normally.
//  pi_flag during EXEC: the byte is ignored (cannot occur at legal baud rates).
//  Reset asserted mid-frame: all state returns to reset values immediately (async).
//   The partial frame is lost and no pulse is generated.
//  Configuration registers change only in EXEC. A rejected frame never alters
//   data/point/sign/seg_en.
// TESTING
//  1. AA 01 01 E2 40 24 -> 2 clks after CHK: data=123456 (0x1E240), frame_ok=1 for 1 clk,
//     err_code=00.
//  2. AA 01 0F 42 40 92 (1_000_000) -> frame_err pulse, err_code=10, data unchanged.
//  3. AA 02 00 00 15 17, then AA 03 00 00 02 05 -> point=6'b010101, sign=1, seg_en=0,
//     two frame_ok pulses.
//  4. AA 01 01 E2 40 25 (bad CHK) -> frame_err 1 clk after CHK, err_code=01, data unchanged.
//  5. TIMEOUT_MAX=100 in sim: AA 01, then idle 100 clks -> frame_err, err_code=11, state IDLE.
//     Then AA 03 00 00 01 04 -> frame_ok, seg_en=1.
//  6. Noise bytes 12 AA(partial) + reset mid-frame; then 55 AA 01 00 00 07 08 ->
//     the 55 is ignored, the frame is accepted, data=7.

Source files
------------

// File: rtl/uart_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_frame_ctrl
//
// Command-frame controller sitting between a UART byte receiver and a 6-digit
// seven-segment display driver. Frames are six bytes: AA, CMD, D2, D1, D0, CHK.
// CHK is the 8-bit wrapping sum of CMD+D2+D1+D0. A frame that passes the
// checksum is executed in a single EXEC cycle, which is the only place the
// display configuration registers are written. Every frame outcome (accepted,
// checksum error, bad command/range, inter-byte timeout) produces exactly one
// single-cycle frame_ok or frame_err pulse, and err_code records the last
// outcome.
//
// Handshake: pi_flag is a one-cycle strobe qualifying pi_data. There is no
// back-pressure; a byte is consumed on the cycle pi_flag is high, except in
// EXEC, where it is dropped.
//
// Ports
//   sys_clk      in   1   system clock
//   sys_rst_n    in   1   asynchronous active-low reset
//   pi_data      in   8   received byte
//   pi_flag      in   1   pi_data valid strobe
//   data         out  20  display value, binary, 0..DATA_MAX
//   point        out  6   decimal-point enable per digit, bit0 = rightmost
//   sign         out  1   1 = show minus sign
//   seg_en       out  1   1 = display on
//   frame_ok     out  1   one-cycle pulse: frame accepted and applied
//   frame_err    out  1   one-cycle pulse: frame rejected
//   err_code     out  2   last error: 00 none, 01 checksum, 10 cmd/range, 11 timeout
//   o_dbg_state  out  3   current FSM state (IDLE=0, CMD=1, D2=2, D1=3, D0=4,
//                         CHK=5, EXEC=6)
// -----------------------------------------------------------------------------
module uart_frame_ctrl #(
    parameter int unsigned TIMEOUT_MAX = 500_000,
    parameter int unsigned DATA_MAX    = 999_999
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  pi_data,
    input  logic        pi_flag,
    output logic [19:0] data,
    output logic [5:0]  point,
    output logic        sign,
    output logic        seg_en,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic [2:0]  o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_D2   = 3'd2,
        S_D1   = 3'd3,
        S_D0   = 3'd4,
        S_CHK  = 3'd5,
        S_EXEC = 3'd6
    } state_t;

    localparam logic [7:0]  SYNC_BYTE = 8'hAA;
    localparam logic [19:0] CNT_LAST  = 20'(TIMEOUT_MAX - 1);
    localparam logic [19:0] VALUE_MAX = 20'(DATA_MAX);

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CHKSUM  = 2'b01;
    localparam logic [1:0] ERR_CMD     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    state_t      r_state;
    state_t      w_next_state;
    logic [19:0] r_cnt;
    logic [7:0]  r_cmd;
    logic [7:0]  r_d2;
    logic [7:0]  r_d1;
    logic [7:0]  r_d0;

    logic        w_active;
    logic        w_timeout;
    logic [7:0]  w_sum;
    logic [19:0] w_value;
    logic        w_ok;
    logic        w_err;
    logic [1:0]  w_err_code;
    logic        w_ld_data;
    logic        w_ld_point;
    logic        w_ld_ctrl;

    // The inter-byte timer only matters while a frame is partially received.
    assign w_active  = (r_state == S_CMD) || (r_state == S_D2) || (r_state == S_D1) ||
                       (r_state == S_D0)  || (r_state == S_CHK);
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign w_timeout = w_active && !pi_flag && (r_cnt == CNT_LAST);

    assign w_sum   = r_cmd + r_d2 + r_d1 + r_d0;
    assign w_value = {r_d2[3:0], r_d1, r_d0};

    assign o_dbg_state = r_state;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and per-cycle actions
    // -------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_ok         = 1'b0;
        w_err        = 1'b0;
        w_err_code   = ERR_NONE;
        w_ld_data    = 1'b0;
        w_ld_point   = 1'b0;
        w_ld_ctrl    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (pi_flag && (pi_data == SYNC_BYTE)) begin
                    w_next_state = S_CMD;
                end
            end

            // 0xAA is plain payload in these states; no resync mid-frame.
            S_CMD, S_D2, S_D1, S_D0: begin
                if (pi_flag) begin
                    w_next_state = state_t'(r_state + 3'd1);
                end else if (w_timeout) begin
                    w_next_state = S_IDLE;
                    w_err        = 1'b1;
                    w_err_code   = ERR_TIMEOUT;
                end
            end

            S_CHK: begin
                if (pi_flag) begin
                    if (pi_data == w_sum) begin
                        w_next_state = S_EXEC;
                    end else begin
                        w_next_state = S_IDLE;
                        w_err        = 1'b1;
                        w_err_code   = ERR_CHKSUM;
                    end
                end else if (w_timeout) begin
                    w_next_state = S_IDLE;
                    w_err        = 1'b1;
                    w_err_code   = ERR_TIMEOUT;
                end
            end

            S_EXEC: begin
                w_next_state = S_IDLE;
                unique case (r_cmd)
                    8'h01: begin
                        // Upper nibble of D2 must be zero, and the value must
                        // fit the six decimal digits.
                        if ((r_d2[7:4] == 4'd0) && (w_value <= VALUE_MAX)) begin
                            w_ld_data = 1'b1;
                            w_ok      = 1'b1;
                        end else begin
                            w_err      = 1'b1;
                            w_err_code = ERR_CMD;
                        end
                    end
                    8'h02: begin
                        w_ld_point = 1'b1;
                        w_ok       = 1'b1;
                    end
                    8'h03: begin
                        w_ld_ctrl = 1'b1;
                        w_ok      = 1'b1;
                    end
                    default: begin
                        w_err      = 1'b1;
                        w_err_code = ERR_CMD;
                    end
                endcase
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Inter-byte timeout counter
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt <= '0;
        end else if (!w_active || pi_flag || w_timeout) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 20'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Frame byte capture
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cmd <= '0;
            r_d2  <= '0;
            r_d1  <= '0;
            r_d0  <= '0;
        end else if (pi_flag) begin
            case (r_state)
                S_CMD:   r_cmd <= pi_data;
                S_D2:    r_d2  <= pi_data;
                S_D1:    r_d1  <= pi_data;
                S_D0:    r_d0  <= pi_data;
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Result pulses, error code and display configuration
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= ERR_NONE;
            data      <= '0;
            point     <= '0;
            sign      <= 1'b0;
            seg_en    <= 1'b1;
        end else begin
            frame_ok  <= w_ok;
            frame_err <= w_err;
            if (w_ok) begin
                err_code <= ERR_NONE;
            end else if (w_err) begin
                err_code <= w_err_code;
            end
            if (w_ld_data) begin
                data <= w_value;
            end
            if (w_ld_point) begin
                point <= r_d0[5:0];
            end
            if (w_ld_ctrl) begin
                seg_en <= r_d0[0];
                sign   <= r_d0[1];
            end
        end
    end

endmodule
